// File: rtl/ice40_ram_pkg.sv
// Shared constants and FSM state type for the two-requester iCE40 BRAM arbiter.
package ice40_ram_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 16;

    localparam logic [15:0] FILL_PATTERN = 16'h0000;

    typedef enum logic {
        StInit,
        StRun
    } arb_state_e;

endpackage

// File: rtl/ice40_rr_arb2.sv
// Two-input arbiter: round-robin pointer that only rotates on a contended grant,
// or fixed priority to A. 'hold' suppresses the grant and freezes the pointer.
module ice40_rr_arb2 #(
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    input  logic hold,
    output logic win_a,
    output logic win_b,
    output logic gnt_a,
    output logic gnt_b
);

    logic ptr_b_q, ptr_b_d;

    always_comb begin
        win_a   = req_a & (PRIO_FIXED | ~req_b | ~ptr_b_q);
        win_b   = req_b & ~win_a;
        gnt_a   = win_a & ~hold;
        gnt_b   = win_b & ~hold;
        ptr_b_d = ptr_b_q;
        if (!PRIO_FIXED && req_a && req_b && !hold) begin
            ptr_b_d = ~ptr_b_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_b_q <= 1'b0;
        end else begin
            ptr_b_q <= ptr_b_d;
        end
    end

endmodule

// File: rtl/sb_ram40_4k.sv
// Behavioural stand-in for the iCE40 SB_RAM40_4K primitive, 256x16 mode only.
// Read-during-write to the same address returns the old word.
module SB_RAM40_4K #(
    parameter int READ_MODE  = 0,
    parameter int WRITE_MODE = 0
) (
    output logic [15:0] RDATA,
    input  logic        RCLK,
    input  logic        RCLKE,
    input  logic        RE,
    input  logic [10:0] RADDR,
    input  logic        WCLK,
    input  logic        WCLKE,
    input  logic        WE,
    input  logic [10:0] WADDR,
    input  logic [15:0] MASK,
    input  logic [15:0] WDATA
);

    localparam bit Mode256x16 = (READ_MODE == 0) && (WRITE_MODE == 0);

    logic [15:0] mem [256];
    logic        unused_hi;

    // Address bits [10:8] select nothing in 256x16 mode.
    assign unused_hi = ^{RADDR[10:8], WADDR[10:8]};

    always_ff @(posedge RCLK) begin
        if (RCLKE && RE) begin
            RDATA <= mem[RADDR[7:0]];
        end
    end

    always_ff @(posedge WCLK) begin
        if (WCLKE && WE && Mode256x16) begin
            mem[WADDR[7:0]] <= (mem[WADDR[7:0]] & MASK) | (WDATA & ~MASK);
        end
    end

endmodule

// File: rtl/ice40_ram_arb2.sv
// Two-client read/write arbiter in front of one SB_RAM40_4K (256x16).
// Define ICE40_RAM_ARB2_CLEAR_EN to zero-fill the RAM after every reset.
module ice40_ram_arb2 #(
    parameter int unsigned ADDR_W     = ice40_ram_pkg::ADDR_W,
    parameter int unsigned DATA_W     = ice40_ram_pkg::DATA_W,
    parameter bit          PRIO_FIXED = 1'b0
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              A_RREQ,
    input  logic [ADDR_W-1:0] A_RADDR,
    output logic              A_RGNT,
    output logic              A_RVALID,
    output logic [DATA_W-1:0] A_RDATA,
    input  logic              A_WREQ,
    input  logic [ADDR_W-1:0] A_WADDR,
    input  logic [DATA_W-1:0] A_WDATA,
    input  logic [DATA_W-1:0] A_WMASK,
    output logic              A_WGNT,
    input  logic              B_RREQ,
    input  logic [ADDR_W-1:0] B_RADDR,
    output logic              B_RGNT,
    output logic              B_RVALID,
    output logic [DATA_W-1:0] B_RDATA,
    input  logic              B_WREQ,
    input  logic [ADDR_W-1:0] B_WADDR,
    input  logic [DATA_W-1:0] B_WDATA,
    input  logic [DATA_W-1:0] B_WMASK,
    output logic              B_WGNT,
    output logic              BUSY
);

    import ice40_ram_pkg::*;

`ifdef ICE40_RAM_ARB2_CLEAR_EN
    localparam arb_state_e ResetState = StInit;
`else
    localparam arb_state_e ResetState = StRun;
`endif

    arb_state_e state_q, state_d;

    logic              run;
    logic              r_win_a, r_win_b, r_gnt_a, r_gnt_b;
    logic              w_win_a, w_win_b, w_gnt_a, w_gnt_b;
    logic              collide, r_hold, w_hold;
    logic [ADDR_W-1:0] r_addr_win, w_addr_win;
    logic              ram_re, ram_we;
    logic [ADDR_W-1:0] ram_raddr, ram_waddr;
    logic [DATA_W-1:0] ram_wdata, ram_mask, ram_rdata;
    logic              rvalid_a_q, rvalid_b_q;

    // Grants are masked combinationally while reset is held so nothing transfers.
    assign run        = RESETN && (state_q == StRun);
    assign r_addr_win = r_win_b ? B_RADDR : A_RADDR;
    assign w_addr_win = w_win_b ? B_WADDR : A_WADDR;

    // A same-address read would see stale data, so the write goes first.
    assign collide = (r_win_a | r_win_b) & (w_win_a | w_win_b) & (r_addr_win == w_addr_win);
    assign r_hold  = ~run | collide;
    assign w_hold  = ~run;

    ice40_rr_arb2 #(
        .PRIO_FIXED(PRIO_FIXED)
    ) u_rd_arb (
        .clk  (CLK),
        .rst_n(RESETN),
        .req_a(A_RREQ),
        .req_b(B_RREQ),
        .hold (r_hold),
        .win_a(r_win_a),
        .win_b(r_win_b),
        .gnt_a(r_gnt_a),
        .gnt_b(r_gnt_b)
    );

    ice40_rr_arb2 #(
        .PRIO_FIXED(PRIO_FIXED)
    ) u_wr_arb (
        .clk  (CLK),
        .rst_n(RESETN),
        .req_a(A_WREQ),
        .req_b(B_WREQ),
        .hold (w_hold),
        .win_a(w_win_a),
        .win_b(w_win_b),
        .gnt_a(w_gnt_a),
        .gnt_b(w_gnt_b)
    );

`ifdef ICE40_RAM_ARB2_CLEAR_EN
    logic [7:0] clr_q;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            clr_q <= 8'd0;
        end else if (state_q == StInit) begin
            clr_q <= clr_q + 8'd1;
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q <= ResetState;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
`ifdef ICE40_RAM_ARB2_CLEAR_EN
        if (state_q == StInit && clr_q == 8'hFF) begin
            state_d = StRun;
        end
`endif
    end

    always_comb begin
        ram_re    = r_gnt_a | r_gnt_b;
        ram_raddr = r_gnt_b ? B_RADDR : A_RADDR;
        ram_we    = w_gnt_a | w_gnt_b;
        ram_waddr = w_addr_win;
        ram_wdata = w_win_b ? B_WDATA : A_WDATA;
        ram_mask  = w_win_b ? B_WMASK : A_WMASK;
`ifdef ICE40_RAM_ARB2_CLEAR_EN
        BUSY = (state_q == StInit);
        if (RESETN && state_q == StInit) begin
            ram_we    = 1'b1;
            ram_waddr = ADDR_W'(clr_q);
            ram_wdata = DATA_W'(FILL_PATTERN);
            ram_mask  = '0;
        end
`else
        BUSY = 1'b0;
`endif
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
        end else begin
            rvalid_a_q <= r_gnt_a;
            rvalid_b_q <= r_gnt_b;
        end
    end

    SB_RAM40_4K #(
        .READ_MODE (0),
        .WRITE_MODE(0)
    ) u_ram (
        .RDATA(ram_rdata),
        .RCLK (CLK),
        .RCLKE(1'b1),
        .RE   (ram_re),
        .RADDR(11'(ram_raddr)),
        .WCLK (CLK),
        .WCLKE(1'b1),
        .WE   (ram_we),
        .WADDR(11'(ram_waddr)),
        .MASK (ram_mask),
        .WDATA(ram_wdata)
    );

    assign A_RGNT   = r_gnt_a;
    assign B_RGNT   = r_gnt_b;
    assign A_WGNT   = w_gnt_a;
    assign B_WGNT   = w_gnt_b;
    assign A_RVALID = rvalid_a_q & RESETN;
    assign B_RVALID = rvalid_b_q & RESETN;
    assign A_RDATA  = ram_rdata;
    assign B_RDATA  = ram_rdata;

endmodule

// File: tb/tb_ice40_ram_arb2.sv
// Scoreboard bench for ice40_ram_arb2: a round-robin and a fixed-priority instance
// share stimulus; read results are predicted from a bench-side memory model.
module tb_ice40_ram_arb2;

`ifdef ICE40_RAM_ARB2_CLEAR_EN
    localparam bit ClearEn = 1'b1;
`else
    localparam bit ClearEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_rreq, b_rreq, a_wreq, b_wreq;
    logic [7:0]  a_raddr, b_raddr, a_waddr, b_waddr;
    logic [15:0] a_wdata, b_wdata, a_wmask, b_wmask;
    logic        a_rgnt, b_rgnt, a_wgnt, b_wgnt, a_rvalid, b_rvalid, busy;
    logic [15:0] a_rdata, b_rdata;
    logic        f_a_rgnt, f_b_rgnt, f_a_wgnt, f_b_wgnt;
    logic        unused_f_a_rvalid, unused_f_b_rvalid, unused_f_busy;
    logic [15:0] unused_f_a_rdata, unused_f_b_rdata;

    typedef struct packed {
        logic        is_b;
        logic [15:0] data;
    } rd_exp_t;

    rd_exp_t     exp_q[$];
    rd_exp_t     exp_e;
    logic [15:0] model_mem [256];
    logic        exp_ra, exp_rb, exp_wa, exp_wb;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    ice40_ram_arb2 #(.PRIO_FIXED(1'b0)) u_dut (
        .CLK(clk), .RESETN(rst_n),
        .A_RREQ(a_rreq), .A_RADDR(a_raddr), .A_RGNT(a_rgnt), .A_RVALID(a_rvalid),
        .A_RDATA(a_rdata), .A_WREQ(a_wreq), .A_WADDR(a_waddr), .A_WDATA(a_wdata),
        .A_WMASK(a_wmask), .A_WGNT(a_wgnt),
        .B_RREQ(b_rreq), .B_RADDR(b_raddr), .B_RGNT(b_rgnt), .B_RVALID(b_rvalid),
        .B_RDATA(b_rdata), .B_WREQ(b_wreq), .B_WADDR(b_waddr), .B_WDATA(b_wdata),
        .B_WMASK(b_wmask), .B_WGNT(b_wgnt), .BUSY(busy)
    );

    ice40_ram_arb2 #(.PRIO_FIXED(1'b1)) u_dut_fixed (
        .CLK(clk), .RESETN(rst_n),
        .A_RREQ(a_rreq), .A_RADDR(a_raddr), .A_RGNT(f_a_rgnt), .A_RVALID(unused_f_a_rvalid),
        .A_RDATA(unused_f_a_rdata), .A_WREQ(a_wreq), .A_WADDR(a_waddr), .A_WDATA(a_wdata),
        .A_WMASK(a_wmask), .A_WGNT(f_a_wgnt),
        .B_RREQ(b_rreq), .B_RADDR(b_raddr), .B_RGNT(f_b_rgnt), .B_RVALID(unused_f_b_rvalid),
        .B_RDATA(unused_f_b_rdata), .B_WREQ(b_wreq), .B_WADDR(b_waddr), .B_WDATA(b_wdata),
        .B_WMASK(b_wmask), .B_WGNT(f_b_wgnt), .BUSY(unused_f_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One request cycle: g/fg are expected {A_RGNT,B_RGNT,A_WGNT,B_WGNT} for each instance.
    task automatic cyc(input string tag, input logic [3:0] g, input logic [3:0] fg);
        {exp_ra, exp_rb, exp_wa, exp_wb} = g;
        #1;
        check({tag, "_gnt"}, 32'({a_rgnt, b_rgnt, a_wgnt, b_wgnt}), 32'(g));
        check({tag, "_fgnt"}, 32'({f_a_rgnt, f_b_rgnt, f_a_wgnt, f_b_wgnt}), 32'(fg));
        @(negedge clk);
    endtask

    // Scoreboard: push expected read data at the granting edge, compare one cycle later.
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (exp_ra) exp_q.push_back({1'b0, model_mem[a_raddr]});
            else if (exp_rb) exp_q.push_back({1'b1, model_mem[b_raddr]});
            if (exp_wa) begin
                model_mem[a_waddr] = (model_mem[a_waddr] & a_wmask) | (a_wdata & ~a_wmask);
            end else if (exp_wb) begin
                model_mem[b_waddr] = (model_mem[b_waddr] & b_wmask) | (b_wdata & ~b_wmask);
            end
        end
        #1;
        if (exp_q.size() != 0) begin
            exp_e = exp_q.pop_front();
            check("rvalid", 32'({a_rvalid, b_rvalid}), 32'({~exp_e.is_b, exp_e.is_b}));
            check("rdata", 32'(exp_e.is_b ? b_rdata : a_rdata), 32'(exp_e.data));
        end else begin
            check("rvalid_idle", 32'({a_rvalid, b_rvalid}), 32'd0);
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        {a_rreq, b_rreq, a_wreq, b_wreq} = '0;
        {a_raddr, b_raddr, a_waddr, b_waddr} = '0;
        {a_wdata, b_wdata, a_wmask, b_wmask} = '0;
        {exp_ra, exp_rb, exp_wa, exp_wb} = '0;
        @(negedge clk);
        cyc("rst0", 4'b0000, 4'b0000);
        cyc("rst1", 4'b0000, 4'b0000);
        check("busy_rst", 32'(busy), 32'(ClearEn));
        rst_n = 1'b1;

        if (ClearEn) begin
            // Request during the clear: it must not be granted until BUSY drops.
            a_rreq = 1'b1;
            a_raddr = 8'h00;
            n = 0;
            while (busy && n < 400) begin
                if (n == 100) begin
                    #1;
                    check("init_gnt", 32'({a_rgnt, b_rgnt, a_wgnt, b_wgnt}), 32'd0);
                end
                @(negedge clk);
                n++;
            end
            check("busy_cycles", 32'(n), 32'd256);
            for (int i = 0; i < 256; i++) model_mem[i] = 16'h0000;
            cyc("rd00", 4'b1000, 4'b1000);
            a_raddr = 8'hFF;
            cyc("rdff", 4'b1000, 4'b1000);
            a_rreq = 1'b0;
        end else begin
            #1;
            check("busy_run", 32'(busy), 32'd0);
            @(negedge clk);
        end

        // Full write, then read-back the next cycle.
        a_wreq = 1'b1; a_waddr = 8'h12; a_wdata = 16'hBEEF; a_wmask = 16'h0000;
        cyc("wr12", 4'b0010, 4'b0010);
        a_wreq = 1'b0; a_rreq = 1'b1; a_raddr = 8'h12;
        cyc("rd12", 4'b1000, 4'b1000);
        // Masked write keeps the low byte: expected 0x12EF.
        a_rreq = 1'b0; a_wreq = 1'b1; a_wdata = 16'h1234; a_wmask = 16'h00FF;
        cyc("wr12m", 4'b0010, 4'b0010);
        a_wreq = 1'b0; a_rreq = 1'b1;
        cyc("rd12m", 4'b1000, 4'b1000);
        a_rreq = 1'b0;

        // Contended writes: alternate under round-robin, A always under fixed priority.
        a_wreq = 1'b1; a_waddr = 8'h20; a_wdata = 16'h1111; a_wmask = 16'h0000;
        b_wreq = 1'b1; b_waddr = 8'h30; b_wdata = 16'h2222; b_wmask = 16'h0000;
        cyc("wrr0", 4'b0010, 4'b0010);
        cyc("wrr1", 4'b0001, 4'b0010);
        cyc("wrr2", 4'b0010, 4'b0010);
        cyc("wrr3", 4'b0001, 4'b0010);
        a_wreq = 1'b0; b_wreq = 1'b0;

        // Contended reads: pointer starts at A, then rotates to B.
        a_rreq = 1'b1; a_raddr = 8'h20; b_rreq = 1'b1; b_raddr = 8'h30;
        cyc("rrd0", 4'b1000, 4'b1000);
        a_rreq = 1'b0;
        cyc("rrd1", 4'b0100, 4'b0100);
        a_rreq = 1'b1; a_raddr = 8'h12; b_raddr = 8'h20;
        cyc("rrd2", 4'b0100, 4'b1000);
        b_rreq = 1'b0;
        cyc("rrd3", 4'b1000, 4'b1000);
        a_rreq = 1'b0;

        // Same-address read/write: write wins, read follows with the new word.
        a_wreq = 1'b1; a_waddr = 8'h40; a_wdata = 16'h5A5A; a_wmask = 16'h0000;
        b_rreq = 1'b1; b_raddr = 8'h40;
        cyc("col0", 4'b0010, 4'b0010);
        a_wreq = 1'b0;
        cyc("col1", 4'b0100, 4'b0100);
        b_rreq = 1'b0;

        // Reset before the read edge: grants drop and no RVALID follows.
        a_rreq = 1'b1; a_raddr = 8'h12;
        {exp_ra, exp_rb, exp_wa, exp_wb} = '0;
        #1;
        check("rst_pre_gnt", 32'(a_rgnt), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_gnt", 32'({a_rgnt, b_rgnt, a_wgnt, b_wgnt}), 32'd0);
        @(negedge clk);
        check("rst_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
        rst_n = 1'b1; a_rreq = 1'b0;
        cyc("post_rst", 4'b0000, 4'b0000);
        check("busy_rst2", 32'(busy), 32'(ClearEn));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
